// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter: locks one requester per burst and steers its stream through a shared
// 2**SEL:1 mux onto a single valid/ready port, with an optional forced release after MAX_BEATS beats.
module mux_rr_arbiter #(
  parameter int BUS_WIDTH = 4,
  parameter int SEL       = 5,
  parameter int MAX_BEATS = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [(2**SEL)-1:0]             req_valid,
  input  logic [(2**SEL)-1:0]             req_last,
  input  logic [BUS_WIDTH*(2**SEL)-1:0]   data_in,
  output logic [(2**SEL)-1:0]             req_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BUS_WIDTH-1:0]            out_data,
  output logic                            out_last,
  output logic [SEL-1:0]                  grant_idx,
  output logic                            busy
);

  localparam int N = 2**SEL;
  localparam bit LIMIT_EN = (MAX_BEATS != 0);
  localparam int FORCE_AT_INT = LIMIT_EN ? (MAX_BEATS - 1) : 0;
  localparam logic [7:0] FORCE_AT = 8'(FORCE_AT_INT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [SEL-1:0]   grant_q, grant_d;
  logic [SEL-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;

  logic             found;
  logic [SEL-1:0]   pick_idx;
  logic [SEL-1:0]   cand;
  logic             force_rel;
  logic             xfer;
  logic [BUS_WIDTH-1:0] sel_data;

  // Rotating priority search starting at rr_ptr; SEL-bit addition wraps modulo N.
  always_comb begin
    found    = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = rr_ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = rr_ptr_q + SEL'(k);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_q;
  assign sel_data  = data_in[grant_q*BUS_WIDTH +: BUS_WIDTH];
  assign out_data  = busy ? sel_data : '0;
  assign out_valid = busy & req_valid[grant_q];
  assign force_rel = LIMIT_EN && (beat_cnt_q == FORCE_AT);
  assign out_last  = out_valid & (req_last[grant_q] | force_rel);
  assign xfer      = out_valid & out_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign req_ready[gi] = busy && (grant_q == SEL'(gi)) && out_ready;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick_idx;
          beat_cnt_d = 8'd0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
          if (out_last) begin
            rr_ptr_d = grant_q + SEL'(1);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one limited-burst instance and one unlimited instance on shared inputs.
module tb_mux_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] data_in;
  logic        out_ready;

  logic [3:0]  req_ready, nl_req_ready;
  logic        out_valid, nl_out_valid;
  logic [7:0]  out_data, nl_out_data;
  logic        out_last, nl_out_last;
  logic [1:0]  grant_idx, nl_grant_idx;
  logic        busy, nl_busy;

  int n_chk;
  int n_fail;

  mux_rr_arbiter #(.BUS_WIDTH(8), .SEL(2), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .data_in(data_in),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .grant_idx(grant_idx), .busy(busy)
  );

  mux_rr_arbiter #(.BUS_WIDTH(8), .SEL(2), .MAX_BEATS(0)) dut_nl (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .data_in(data_in),
    .req_ready(nl_req_ready), .out_valid(nl_out_valid), .out_ready(out_ready), .out_data(nl_out_data),
    .out_last(nl_out_last), .grant_idx(nl_grant_idx), .busy(nl_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [7:0] v);
    data_in[idx*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    data_in   = 32'h0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if ({busy, out_valid, req_ready, grant_idx, out_last} !== 9'd0) begin n_fail++; $display("FAIL reset_idle: got %b required 0", {busy, out_valid, req_ready, grant_idx, out_last}); end
    req_valid = 4'b0100; req_last = 4'b0100; set_data(2, 8'h5A); out_ready = 1'b1;
    step(); #1;
    n_chk++; if ({busy, grant_idx, out_last} !== {1'b1, 2'd2, 1'b1}) begin n_fail++; $display("FAIL reset_pregrant: got busy=%b grant=%0d last=%b required busy=1 grant=2 last=1", busy, grant_idx, out_last); end
    #2; rst_n = 1'b0; #1;
    n_chk++; if ({out_valid, busy, req_ready, grant_idx, out_last, out_data} !== 17'd0) begin n_fail++; $display("FAIL reset_async: got %h required 0", {out_valid, busy, req_ready, grant_idx, out_last, out_data}); end
    step();
    rst_n = 1'b1; req_valid = 4'b1010; req_last = 4'b0000;
    step(); #1;
    n_chk++; if ({busy, grant_idx} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL reset_lowest_grant: got busy=%b grant=%0d required busy=1 grant=1", busy, grant_idx); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0010; set_data(1, 8'hA1); out_ready = 1'b1; #1;
    n_chk++; if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL single_latency: got busy=%b valid=%b required 0 0", busy, out_valid); end
    step(); #1;
    n_chk++; if ({busy, grant_idx, out_valid, req_ready} !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin n_fail++; $display("FAIL single_grant: got busy=%b grant=%0d valid=%b ready=%b required 1 1 1 0010", busy, grant_idx, out_valid, req_ready); end
    for (int b = 1; b <= 3; b++) begin
      if (b > 1) begin step(); set_data(1, 8'hA0 + 8'(b)); end
      if (b == 3) req_last = 4'b0010;
      #1;
      n_chk++; if ({out_data, out_last} !== {8'hA0 + 8'(b), (b == 3)}) begin n_fail++; $display("FAIL single_beat%0d: got data=%h last=%b required data=%h last=%b", b, out_data, out_last, 8'hA0 + 8'(b), (b == 3)); end
    end
    step();
    req_valid = 4'b1101; req_last = 4'b0000; #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got busy=%b required 0", busy); end
    step(); #1;
    n_chk++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL single_rr_ptr: got grant=%0d required 2", grant_idx); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 8'hD0 + 8'(i));
    for (int k = 0; k < 8; k++) begin
      step(); #1;
      n_chk++; if ({busy, grant_idx, out_data, out_last} !== {1'b1, 2'(k % 4), 8'hD0 + 8'(k % 4), 1'b1}) begin n_fail++; $display("FAIL rr_grant%0d: got busy=%b grant=%0d data=%h last=%b required 1 %0d %h 1", k, busy, grant_idx, out_data, out_last, k % 4, 8'hD0 + 8'(k % 4)); end
      step(); #1;
      n_chk++; if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL rr_bubble%0d: got busy=%b valid=%b required 0 0", k, busy, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] rdy_pat;
    int nb;
    do_reset();
    rdy_pat = 6'b111001;
    nb = 1;
    req_valid = 4'b0001; set_data(0, 8'hB1); out_ready = 1'b1;
    step();
    for (int c = 0; c < 6; c++) begin
      out_ready = rdy_pat[c];
      set_data(0, 8'hB0 + 8'(nb));
      #1;
      n_chk++; if ({req_ready, out_data, out_last} !== {3'b000, rdy_pat[c], 8'hB0 + 8'(nb), (nb == 4)}) begin n_fail++; $display("FAIL bp_cycle%0d: got ready=%b data=%h last=%b required ready=000%b data=%h last=%b", c, req_ready, out_data, out_last, rdy_pat[c], 8'hB0 + 8'(nb), (nb == 4)); end
      step();
      if (rdy_pat[c]) nb++;
    end
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got busy=%b required 0", busy); end
  endtask

  task automatic test_forced_release();
    do_reset();
    req_valid = 4'b1100; req_last = 4'b1000; out_ready = 1'b1;
    set_data(2, 8'hC1); set_data(3, 8'hDD);
    step();
    for (int b = 1; b <= 4; b++) begin
      #1;
      n_chk++; if ({grant_idx, out_data, out_last} !== {2'd2, 8'hC0 + 8'(b), (b == 4)}) begin n_fail++; $display("FAIL force_beat%0d: got grant=%0d data=%h last=%b required 2 %h %b", b, grant_idx, out_data, out_last, 8'hC0 + 8'(b), (b == 4)); end
      step();
      set_data(2, 8'hC0 + 8'(b + 1));
    end
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL force_release: got busy=%b required 0", busy); end
    step(); #1;
    n_chk++; if ({grant_idx, out_data, out_last} !== {2'd3, 8'hDD, 1'b1}) begin n_fail++; $display("FAIL force_next_grant: got grant=%0d data=%h last=%b required 3 dd 1", grant_idx, out_data, out_last); end
    step();
    req_valid = 4'b0100;
    step(); #1;
    n_chk++; if ({grant_idx, out_data, out_last} !== {2'd2, 8'hC5, 1'b0}) begin n_fail++; $display("FAIL force_regrant: got grant=%0d data=%h last=%b required 2 c5 0", grant_idx, out_data, out_last); end
    step();
    set_data(2, 8'hC6); req_last = 4'b0100; #1;
    n_chk++; if ({out_data, out_last} !== {8'hC6, 1'b1}) begin n_fail++; $display("FAIL force_tail: got data=%h last=%b required c6 1", out_data, out_last); end
    step(); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL force_tail_release: got busy=%b required 0", busy); end
  endtask

  task automatic test_unlimited();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b1;
    set_data(2, 8'hC1);
    step();
    for (int b = 1; b <= 6; b++) begin
      if (b == 6) req_last = 4'b0100;
      #1;
      n_chk++; if ({nl_grant_idx, nl_out_valid, nl_req_ready, nl_out_data, nl_out_last} !== {2'd2, 1'b1, 4'b0100, 8'hC0 + 8'(b), (b == 6)}) begin n_fail++; $display("FAIL unlim_beat%0d: got grant=%0d valid=%b ready=%b data=%h last=%b required 2 1 0100 %h %b", b, nl_grant_idx, nl_out_valid, nl_req_ready, nl_out_data, nl_out_last, 8'hC0 + 8'(b), (b == 6)); end
      step();
      set_data(2, 8'hC0 + 8'(b + 1));
    end
    #1;
    n_chk++; if (nl_busy !== 1'b0) begin n_fail++; $display("FAIL unlim_release: got busy=%b required 0", nl_busy); end
  endtask

  task automatic test_valid_gap();
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0000; out_ready = 1'b1;
    set_data(1, 8'hE1); set_data(0, 8'h0F);
    step(); #1;
    n_chk++; if ({grant_idx, out_valid, out_data} !== {2'd1, 1'b1, 8'hE1}) begin n_fail++; $display("FAIL gap_first: got grant=%0d valid=%b data=%h required 1 1 e1", grant_idx, out_valid, out_data); end
    step();
    req_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if ({busy, grant_idx, out_valid, req_ready[0]} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL gap_hold%0d: got busy=%b grant=%0d valid=%b ready0=%b required 1 1 0 0", i, busy, grant_idx, out_valid, req_ready[0]); end
      step();
    end
    req_valid = 4'b0011; req_last = 4'b0010; set_data(1, 8'hE2); #1;
    n_chk++; if ({grant_idx, out_valid, out_data, out_last, req_ready} !== {2'd1, 1'b1, 8'hE2, 1'b1, 4'b0010}) begin n_fail++; $display("FAIL gap_resume: got grant=%0d valid=%b data=%h last=%b ready=%b required 1 1 e2 1 0010", grant_idx, out_valid, out_data, out_last, req_ready); end
    step(); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_release: got busy=%b required 0", busy); end
    step(); #1;
    n_chk++; if ({busy, grant_idx} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL gap_next_grant: got busy=%b grant=%0d required 1 0", busy, grant_idx); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    data_in   = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_forced_release();
    test_unlimited();
    test_valid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
